// File: rtl/cpu_exec_pkg.sv
// cpu_exec_pkg: shared definitions for the CPU execution unit.
// Contents: command codes, ALU function codes, flag bit positions,
// motherboard controller request/status codes, sequencer states and
// internal bus source selectors.
package cpu_exec_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_LDT1    = 3'd1,
    CMD_LDT2    = 3'd2,
    CMD_ALU     = 3'd3,
    CMD_SETADDR = 3'd4,
    CMD_SETWD   = 3'd5,
    CMD_MEMWR   = 3'd6,
    CMD_MEMRD   = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADC  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SBB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOT  = 4'd7,
    ALU_SHL1 = 4'd8,
    ALU_SHR1 = 4'd9,
    ALU_SAR1 = 4'd10,
    ALU_INC  = 4'd11,
    ALU_DEC  = 4'd12,
    ALU_PST1 = 4'd13,
    ALU_PST2 = 4'd14,
    ALU_CMP  = 4'd15
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_P = 4;

  localparam logic [1:0] CTRL_NONE  = 2'd0;
  localparam logic [1:0] CTRL_READ  = 2'd1;
  localparam logic [1:0] CTRL_WRITE = 2'd2;

  localparam logic [1:0] STAT_IDLE = 2'd0;
  localparam logic [1:0] STAT_BUSY = 2'd1;
  localparam logic [1:0] STAT_DONE = 2'd2;

  // Last wait-counter value before a timeout abort (255 wait cycles total).
  localparam logic [7:0] TIMEOUT_LAST = 8'd254;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_IMM  = 3'd1,
    BUS_ALU  = 3'd2,
    BUS_T1   = 3'd3,
    BUS_T2   = 3'd4,
    BUS_MEM  = 3'd5
  } bus_src_e;

endpackage

// File: rtl/exec_alu.sv
// exec_alu: purely combinational 16-function ALU.
// Ports:
//   op     - ALU function (alu_op_e)
//   a, b   - operands (T1, T2)
//   cin    - carry/borrow in for ADC/SBB
//   result - function result (CMP returns the SUB difference)
//   flags  - {P, V, N, C, Z}
module exec_alu
  import cpu_exec_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int FLAG_WIDTH = 5
) (
  input  logic [3:0]            op,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [WORD_WIDTH-1:0] result,
  output logic [FLAG_WIDTH-1:0] flags
);

  localparam int W = WORD_WIDTH;

  logic              arith;
  logic              is_sub;
  logic              k;
  logic [W-1:0]      y;
  logic [W:0]        u_res;
  logic signed [W:0] s_res;
  logic              c;
  logic              v;
  logic [W-1:0]      r;

  // Signed result one bit wider than the word: overflow when the top two
  // bits disagree.
  function automatic logic signed_ovf(input logic signed [W:0] s);
    return s[W] ^ s[W-1];
  endfunction

  always_comb begin
    arith  = 1'b0;
    is_sub = 1'b0;
    k      = 1'b0;
    y      = '0;
    r      = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (alu_op_e'(op))
      ALU_ADD:          begin arith = 1'b1; y = b; end
      ALU_ADC:          begin arith = 1'b1; y = b; k = cin; end
      ALU_SUB, ALU_CMP: begin arith = 1'b1; is_sub = 1'b1; y = b; end
      ALU_SBB:          begin arith = 1'b1; is_sub = 1'b1; y = b; k = cin; end
      ALU_INC:          begin arith = 1'b1; y = {{(W-1){1'b0}}, 1'b1}; end
      ALU_DEC:          begin arith = 1'b1; is_sub = 1'b1; y = {{(W-1){1'b0}}, 1'b1}; end
      ALU_AND:          r = a & b;
      ALU_OR:           r = a | b;
      ALU_XOR:          r = a ^ b;
      ALU_NOT:          r = ~a;
      ALU_SHL1:         begin r = {a[W-2:0], 1'b0};   c = a[W-1]; end
      ALU_SHR1:         begin r = {1'b0, a[W-1:1]};   c = a[0];   end
      ALU_SAR1:         begin r = {a[W-1], a[W-1:1]}; c = a[0];   end
      ALU_PST1:         r = a;
      ALU_PST2:         r = b;
      default:          r = '0;
    endcase

    // Unsigned form gives carry (add) or borrow (sub) in bit W; the
    // sign-extended form gives signed overflow.
    if (is_sub) begin
      u_res = {1'b0, a} - {1'b0, y} - {{W{1'b0}}, k};
      s_res = $signed({a[W-1], a}) - $signed({y[W-1], y}) - $signed({{W{1'b0}}, k});
    end else begin
      u_res = {1'b0, a} + {1'b0, y} + {{W{1'b0}}, k};
      s_res = $signed({a[W-1], a}) + $signed({y[W-1], y}) + $signed({{W{1'b0}}, k});
    end

    if (arith) begin
      r = u_res[W-1:0];
      c = u_res[W];
      v = signed_ovf(s_res);
    end
  end

  assign result = r;

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = ~|r;
    flags[FLAG_C] = c;
    flags[FLAG_N] = r[W-1];
    flags[FLAG_V] = v;
    flags[FLAG_P] = ~^r;
  end

endmodule

// File: rtl/cpu_exec_unit.sv
// cpu_exec_unit: T1/T2 temporaries, ALU, internal operand bus and the
// motherboard read/write handshake sequencer behind one valid/ready port.
// Ports:
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_imm - command port
//   alu_opcode, alu_carry              - ALU function and carry-in
//   t1_out, t2_out, alu_flags          - register contents
//   mobo_ctrl, mobo_stat, addr_out,
//   mobodat_out, mobodat_in            - motherboard controller handshake
//   mem_err                            - sticky memory timeout error
// Build option: MOBO_TIMEOUT_EN adds a 255-cycle wait timeout driving
// mem_err; without it the sequencer waits indefinitely and mem_err is 0.
module cpu_exec_unit
  import cpu_exec_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int FLAG_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [WORD_WIDTH-1:0] cmd_imm,
  input  logic [3:0]            alu_opcode,
  input  logic                  alu_carry,
  output logic [WORD_WIDTH-1:0] t1_out,
  output logic [WORD_WIDTH-1:0] t2_out,
  output logic [FLAG_WIDTH-1:0] alu_flags,
  output logic [1:0]            mobo_ctrl,
  input  logic [1:0]            mobo_stat,
  output logic [WORD_WIDTH-1:0] addr_out,
  output logic [WORD_WIDTH-1:0] mobodat_out,
  input  logic [WORD_WIDTH-1:0] mobodat_in,
  output logic                  mem_err
);

  state_e                state_q, state_d;
  logic [1:0]            mobo_ctrl_q, mobo_ctrl_d;
  logic [WORD_WIDTH-1:0] t1_q, t1_d, t2_q, t2_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;

  bus_src_e              bus_src;
  logic [WORD_WIDTH-1:0] bus_data;
  logic                  ld_t1, ld_t2, ld_addr, ld_wd, ld_flags;
  logic [WORD_WIDTH-1:0] alu_res;
  logic [FLAG_WIDTH-1:0] alu_flg;

`ifdef MOBO_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  exec_alu #(
    .WORD_WIDTH(WORD_WIDTH),
    .FLAG_WIDTH(FLAG_WIDTH)
  ) u_alu (
    .op    (alu_opcode),
    .a     (t1_q),
    .b     (t2_q),
    .cin   (alu_carry),
    .result(alu_res),
    .flags (alu_flg)
  );

  assign cmd_ready = (state_q == ST_IDLE);

  // Command decode and handshake sequencing. Exactly one bus source is
  // chosen per cycle, so the bus never has competing drivers.
  always_comb begin
    state_d     = state_q;
    mobo_ctrl_d = mobo_ctrl_q;
    bus_src     = BUS_NONE;
    ld_t1       = 1'b0;
    ld_t2       = 1'b0;
    ld_addr     = 1'b0;
    ld_wd       = 1'b0;
    ld_flags    = 1'b0;
`ifdef MOBO_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_e'(cmd_op))
            CMD_LDT1:    begin bus_src = BUS_IMM; ld_t1 = 1'b1; end
            CMD_LDT2:    begin bus_src = BUS_IMM; ld_t2 = 1'b1; end
            CMD_ALU:     begin
              bus_src  = BUS_ALU;
              ld_t1    = (alu_op_e'(alu_opcode) != ALU_CMP);
              ld_flags = 1'b1;
            end
            CMD_SETADDR: begin bus_src = BUS_T1; ld_addr = 1'b1; end
            CMD_SETWD:   begin bus_src = BUS_T2; ld_wd = 1'b1; end
            CMD_MEMWR:   state_d = ST_WR_REQ;
            CMD_MEMRD:   state_d = ST_RD_REQ;
            default:     ;
          endcase
        end
      end
      // Request is raised only once the controller reports IDLE; a stale
      // DONE here is ignored.
      ST_WR_REQ, ST_RD_REQ: begin
        if (mobo_stat == STAT_IDLE) begin
          mobo_ctrl_d = (state_q == ST_RD_REQ) ? CTRL_READ : CTRL_WRITE;
          state_d     = (state_q == ST_RD_REQ) ? ST_RD_WAIT : ST_WR_WAIT;
`ifdef MOBO_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        if (mobo_stat == STAT_DONE) begin
          mobo_ctrl_d = CTRL_NONE;
          state_d     = ST_IDLE;
          if (state_q == ST_RD_WAIT) begin
            bus_src = BUS_MEM;
            ld_t1   = 1'b1;
          end
        end
`ifdef MOBO_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          mobo_ctrl_d = CTRL_NONE;
          state_d     = ST_IDLE;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d     = ST_IDLE;
        mobo_ctrl_d = CTRL_NONE;
      end
    endcase
  end

  always_comb begin
    unique case (bus_src)
      BUS_IMM: bus_data = cmd_imm;
      BUS_ALU: bus_data = alu_res;
      BUS_T1:  bus_data = t1_q;
      BUS_T2:  bus_data = t2_q;
      BUS_MEM: bus_data = mobodat_in;
      default: bus_data = '0;
    endcase
  end

  always_comb begin
    t1_d    = ld_t1    ? bus_data : t1_q;
    t2_d    = ld_t2    ? bus_data : t2_q;
    addr_d  = ld_addr  ? bus_data : addr_q;
    wdata_d = ld_wd    ? bus_data : wdata_q;
    flags_d = ld_flags ? alu_flg  : flags_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mobo_ctrl_q <= CTRL_NONE;
      t1_q        <= '0;
      t2_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      mobo_ctrl_q <= mobo_ctrl_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      flags_q     <= flags_d;
    end
  end

`ifdef MOBO_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign t1_out      = t1_q;
  assign t2_out      = t2_q;
  assign alu_flags   = flags_q;
  assign mobo_ctrl   = mobo_ctrl_q;
  assign addr_out    = addr_q;
  assign mobodat_out = wdata_q;

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Testbench for cpu_exec_unit: directed scenarios plus randomized register
// and memory commands checked against an arithmetic reference model.
module tb_cpu_exec_unit;
  import cpu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_imm;
  logic [3:0]  alu_opcode;
  logic        alu_carry;
  logic [15:0] t1_out, t2_out;
  logic [4:0]  alu_flags;
  logic [1:0]  mobo_ctrl;
  logic [1:0]  mobo_stat;
  logic [15:0] addr_out, mobodat_out, mobodat_in;
  logic        mem_err;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_t1, m_t2, m_addr, m_wd;
  logic [4:0]  m_flags;
  logic        m_err;

  cpu_exec_unit #(.WORD_WIDTH(16), .FLAG_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_imm    (cmd_imm),
    .alu_opcode (alu_opcode),
    .alu_carry  (alu_carry),
    .t1_out     (t1_out),
    .t2_out     (t2_out),
    .alu_flags  (alu_flags),
    .mobo_ctrl  (mobo_ctrl),
    .mobo_stat  (mobo_stat),
    .addr_out   (addr_out),
    .mobodat_out(mobodat_out),
    .mobodat_in (mobodat_in),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference ALU from the arithmetic definitions using wide integers.
  function automatic void ref_alu(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic cy,
                                  output logic [15:0] r, output logic [4:0] f);
    int ua, ub, ci, sa, sb, full, sfull;
    logic c, v, arith;
    logic signed [15:0] as16;
    ua = a; ub = b; ci = cy; sa = $signed(a); sb = $signed(b); as16 = a;
    c = 1'b0; v = 1'b0; arith = 1'b1; full = 0; sfull = 0; r = '0;
    case (op)
      4'd0:        begin full = ua + ub;      sfull = sa + sb;      end
      4'd1:        begin full = ua + ub + ci; sfull = sa + sb + ci; end
      4'd2, 4'd15: begin full = ua - ub;      sfull = sa - sb;      end
      4'd3:        begin full = ua - ub - ci; sfull = sa - sb - ci; end
      4'd11:       begin full = ua + 1;       sfull = sa + 1;       end
      4'd12:       begin full = ua - 1;       sfull = sa - 1;       end
      default:     arith = 1'b0;
    endcase
    if (arith) begin
      r = full[15:0];
      c = (full < 0) || (full > 65535);
      v = (sfull < -32768) || (sfull > 32767);
    end else begin
      case (op)
        4'd4:  r = a & b;
        4'd5:  r = a | b;
        4'd6:  r = a ^ b;
        4'd7:  r = ~a;
        4'd8:  begin r = a << 1; c = a[15]; end
        4'd9:  begin r = a >> 1; c = a[0];  end
        4'd10: begin r = as16 >>> 1; c = a[0]; end
        4'd13: r = a;
        4'd14: r = b;
        default: r = '0;
      endcase
    end
    f = {($countones(r) % 2 == 0), v, r[15], c, (r == 16'd0)};
  endfunction

  task automatic model_reset();
    m_t1 = '0; m_t2 = '0; m_addr = '0; m_wd = '0; m_flags = '0; m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_t1"},    t1_out,      m_t1);
    check({tag, "_t2"},    t2_out,      m_t2);
    check({tag, "_addr"},  addr_out,    m_addr);
    check({tag, "_wd"},    mobodat_out, m_wd);
    check({tag, "_flags"}, alu_flags,   m_flags);
    check({tag, "_err"},   mem_err,     m_err);
  endtask

  // Issue one register command at a negedge; returns at the following negedge.
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] imm,
                        input logic [3:0] aop, input logic cy);
    logic [15:0] r;
    logic [4:0]  f;
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm; alu_opcode = aop; alu_carry = cy;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    case (op)
      3'd1: m_t1 = imm;
      3'd2: m_t2 = imm;
      3'd3: begin
        ref_alu(aop, m_t1, m_t2, cy, r, f);
        m_flags = f;
        if (aop != 4'd15) m_t1 = r;
      end
      3'd4: m_addr = m_t1;
      3'd5: m_wd = m_t2;
      default: ;
    endcase
  endtask

  // One memory transaction: `pre` cycles of controller BUSY/DONE before IDLE,
  // then `wt` BUSY cycles, then DONE carrying `data`. Stray commands are
  // pulsed while the unit is busy and must be ignored.
  task automatic mem_txn(input bit rd, input int pre, input int wt, input logic [15:0] data);
    logic [1:0] req;
    req = rd ? CTRL_READ : CTRL_WRITE;
    mobo_stat = ($urandom_range(0, 1) != 0) ? STAT_DONE : STAT_BUSY;
    cmd_valid = 1'b1; cmd_op = rd ? 3'd7 : 3'd6;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    check("mem_ready_drop", cmd_ready, 1'b0);
    for (int i = 0; i < pre; i++) begin
      check("mem_req_hold", mobo_ctrl, CTRL_NONE);
      cmd_valid = 1'b1; cmd_op = 3'd2; cmd_imm = 16'($urandom);
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("mem_req_none", mobo_ctrl, CTRL_NONE);
    mobo_stat = STAT_IDLE;
    @(posedge clk); @(negedge clk);
    check("mem_req_issued", mobo_ctrl, req);
    for (int i = 0; i < wt; i++) begin
      mobo_stat = STAT_BUSY; mobodat_in = 16'($urandom);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_imm = 16'($urandom);
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      check("mem_wait_ctrl", mobo_ctrl, req);
      check("mem_wait_ready", cmd_ready, 1'b0);
      check("mem_wait_t1", t1_out, m_t1);
    end
    mobo_stat = STAT_DONE; mobodat_in = data;
    @(posedge clk); @(negedge clk);
    mobo_stat = STAT_IDLE;
    if (rd) m_t1 = data;
    check("mem_done_ctrl", mobo_ctrl, CTRL_NONE);
    check("mem_done_ready", cmd_ready, 1'b1);
    check_all("mem_done");
  endtask

  logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

  initial begin
    int n;
    logic [2:0]  op;
    logic [15:0] imm;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0;
    alu_opcode = '0; alu_carry = 1'b0; mobo_stat = STAT_IDLE; mobodat_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_ctrl", mobo_ctrl, CTRL_NONE);
    rst = 1'b1;
    @(negedge clk);

    // ADD 3 + 5
    do_cmd(3'd1, 16'd3, 4'd0, 1'b0);
    do_cmd(3'd2, 16'd5, 4'd0, 1'b0);
    do_cmd(3'd3, 16'd0, 4'd0, 1'b0);
    check("add_t1", t1_out, 16'd8);
    check("add_flags", alu_flags, 5'b00000);
    check_all("add");

    // SUB 3 - 5 then CMP against equal T2
    do_cmd(3'd1, 16'd3, 4'd0, 1'b0);
    do_cmd(3'd3, 16'd0, 4'd2, 1'b0);
    check("sub_t1", t1_out, 16'hFFFE);
    check("sub_c", alu_flags[1], 1'b1);
    check("sub_n", alu_flags[2], 1'b1);
    check("sub_z", alu_flags[0], 1'b0);
    do_cmd(3'd2, 16'hFFFE, 4'd0, 1'b0);
    do_cmd(3'd3, 16'd0, 4'd15, 1'b0);
    check("cmp_t1", t1_out, 16'hFFFE);
    check("cmp_z", alu_flags[0], 1'b1);
    check_all("cmp");

    // Randomized register commands with corner operands
    for (int i = 0; i < 300; i++) begin
      op  = 3'($urandom_range(0, 5));
      imm = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      do_cmd(op, imm, 4'($urandom), 1'($urandom));
      check_all("rnd");
      check("rnd_ready", cmd_ready, 1'b1);
    end

    // Directed write: addr=3, data=5, BUSY x2 then IDLE, DONE after 3 cycles
    do_cmd(3'd1, 16'd3, 4'd0, 1'b0);
    do_cmd(3'd2, 16'd5, 4'd0, 1'b0);
    do_cmd(3'd4, 16'd0, 4'd0, 1'b0);
    do_cmd(3'd5, 16'd0, 4'd0, 1'b0);
    mem_txn(1'b0, 2, 2, 16'h0000);
    check("wr_addr", addr_out, 16'd3);
    check("wr_data", mobodat_out, 16'd5);

    // Directed read of 0x00AA
    mem_txn(1'b1, 2, 2, 16'h00AA);
    check("rd_t1", t1_out, 16'h00AA);

    // Randomized memory transactions
    for (int i = 0; i < 20; i++)
      mem_txn(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), 16'($urandom));

    // Reset during WR_WAIT
    mobo_stat = STAT_IDLE;
    cmd_valid = 1'b1; cmd_op = 3'd6;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstw_ctrl_write", mobo_ctrl, CTRL_WRITE);
    mobo_stat = STAT_BUSY;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rstw_ctrl_async", mobo_ctrl, CTRL_NONE);
    check_all("rstw_async");
    @(negedge clk);
    rst = 1'b1; mobo_stat = STAT_IDLE;
    @(negedge clk);
    check("rstw_ready", cmd_ready, 1'b1);
    check_all("rstw_after");
    do_cmd(3'd1, 16'h1234, 4'd0, 1'b0);
    check_all("rstw_cmd");

`ifdef MOBO_TIMEOUT_EN
    // Write whose DONE never arrives
    cmd_valid = 1'b1; cmd_op = 3'd6;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("to_ctrl_write", mobo_ctrl, CTRL_WRITE);
    mobo_stat = STAT_BUSY;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, 255);
    check("to_ctrl_none", mobo_ctrl, CTRL_NONE);
    m_err = 1'b1;
    mobo_stat = STAT_IDLE;
    check_all("to_done");
    do_cmd(3'd2, 16'h0F0F, 4'd0, 1'b0);
    check_all("to_sticky");
`else
    n = 0;
    check("no_timeout_err", mem_err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_exec_unit.md
# cpu_exec_unit

CPU execution unit combining the two temporaries T1/T2, a 16-function ALU, the internal operand bus, and the motherboard read/write handshake sequencer. The CPU control FSM drives it with one command at a time. It owns the address and write-data registers presented to the motherboard controller (mobo_ctrl). It replaces ad-hoc per-state register strobes with a single valid/ready command port.

## Interface
- WORD_WIDTH, 16: datapath width (T1, T2, address, data).
- FLAG_WIDTH, 5: ALU flag vector width; fixed at 5.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  high when able to accept a command.
- cmd_op  in  3  command code: 0 NOP, 1 LDT1, 2 LDT2, 3 ALU, 4 SETADDR, 5 SETWD, 6 MEMWR, 7 MEMRD.
- cmd_imm  in  WORD_WIDTH  immediate operand for LDT1/LDT2.
- alu_opcode  in  4  ALU function for the ALU command.
- alu_carry  in  1  carry-in for ADC/SBB.
- t1_out, t2_out  out  WORD_WIDTH  current contents of T1 and T2.
- alu_flags  out  5  registered flags: [0]Z, [1]C, [2]N, [3]V, [4]P (even parity of result).
- mobo_ctrl  out  2  request code: 0 NONE, 1 READ, 2 WRITE (registered).
- mobo_stat  in  2  controller status: 0 IDLE, 1 BUSY, 2 DONE.
- addr_out  out  WORD_WIDTH  address register.
- mobodat_out  out  WORD_WIDTH  write-data register.
- mobodat_in  in  WORD_WIDTH  read data, valid while mobo_stat==DONE.
- mem_err  out  1  sticky timeout error; constant 0 unless the timeout option is compiled in.

## Operation
- Command fires on a rising edge with cmd_valid && cmd_ready. cmd_valid is ignored while cmd_ready is low.
- LDT1 / LDT2: T1 or T2 loads cmd_imm.
- SETADDR: addr <= T1. SETWD: wdata <= T2.
- ALU: T1 <= result; flags <= computed flags.
  - ALU functions: 0 ADD, 1 ADC, 2 SUB (T1−T2), 3 SBB, 4 AND, 5 OR, 6 XOR, 7 NOT T1, 8 SHL1, 9 SHR1, 10 SAR1, 11 INC, 12 DEC, 13 PASS T1, 14 PASS T2, 15 CMP.
  - CMP computes SUB flags and leaves T1 unchanged.
  - C is carry-out for add. For sub, C is the borrow.
  - For shifts, C is the bit shifted out.
  - For logic/pass ops, C is 0.
  - V is signed overflow for add/sub/inc/dec/cmp and 0 otherwise.
  - All arithmetic is modulo 2^WORD_WIDTH.
- MEMWR FSM: IDLE → WR_REQ → WR_WAIT → IDLE.
  - WR_REQ: when mobo_stat==IDLE, mobo_ctrl <= WRITE and go to WR_WAIT.
  - WR_WAIT: when mobo_stat==DONE, mobo_ctrl <= NONE and go to IDLE.
- MEMRD FSM: IDLE → RD_REQ → RD_WAIT → IDLE, with the same handshake using READ.
  - On the DONE edge, T1 <= mobodat_in.
- Internal bus: a single source is selected per command (cmd_imm, ALU result, T1, T2, mobodat_in). Selection is decoded from the command, so there is never a contention case.
- Reset values: T1, T2, addr, wdata, flags = 0; mobo_ctrl = NONE; state = IDLE; mem_err = 0.

## Timing
- Register commands take one cycle; cmd_ready stays high.
- Memory commands: cmd_ready drops the cycle after acceptance and returns high the cycle after the DONE edge.
- Minimum memory command length is 3 cycles: accept, request, done.
- cmd_ready is combinational from state: high only in IDLE.
- mobo_ctrl changes only on clock edges; it is held while waiting.
- If reset asserts mid-transaction, mobo_ctrl = NONE immediately (asynchronous), state = IDLE, and partial read data is discarded.
- DONE seen in REQ state is ignored; the block keeps waiting for IDLE.

## Configuration
- MOBO_TIMEOUT_EN defined:
  - An 8-bit counter runs in the WAIT states.
  - After 255 cycles without DONE: mobo_ctrl <= NONE, state <= IDLE, mem_err <= 1.
  - mem_err is sticky until reset. On a read timeout, T1 is unchanged.
- MOBO_TIMEOUT_EN undefined: the block waits indefinitely and mem_err is tied 0.

## Structure
- Package cpu_exec_pkg holds:
  - command codes
  - ALU opcodes
  - the flag bit indices
  - MOBO CTRL_* / STAT_* codes
  - FSM state encoding
- One sub-module, exec_alu: purely combinational, (op, a, b, cin) → (result, flags).
- T1/T2/bus/FSM stay in the top level.

## Test plan
- LDT1 3, LDT2 5, ALU ADD → t1_out=8, flags Z=0 C=0 N=0 V=0 P=0.
- LDT1 3, LDT2 5, ALU SUB → t1_out=0xFFFE, C=1, N=1, Z=0. Then CMP with T2=0xFFFE → t1_out unchanged, Z=1.
- LDT1 3, LDT2 5, SETADDR, SETWD, MEMWR with mobo_stat BUSY for 2 cycles, then IDLE, then DONE 3 cycles later:
  - mobo_ctrl=WRITE is asserted only after IDLE.
  - addr_out=3, mobodat_out=5.
  - mobo_ctrl=NONE and cmd_ready=1 after DONE.
- MEMRD with mobodat_in=0x00AA at DONE → t1_out=0x00AA. cmd_valid pulses during the wait are ignored.
- Reset asserted in WR_WAIT → mobo_ctrl=NONE without a clock edge, all registers 0, cmd_ready=1 after release.
- With MOBO_TIMEOUT_EN, MEMWR with DONE never arriving → mem_err=1, mobo_ctrl=NONE and state IDLE after the 255-cycle limit.
